// File: rtl/bubble_cpu_mc.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB FSM, regfile, loadable imem/dmem.
// Ports: clk/rst/start, imem/dmem load + debug read, pc/out/busy/halted/illegal status.
module bubble_cpu_mc #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 5,
  parameter int DADDR_W = 5,
  parameter int NREG    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [31:0]        imem_wdata,
  input  logic               dmem_we,
  input  logic [DADDR_W-1:0] dmem_addr,
  input  logic [XLEN-1:0]    dmem_wdata,
  output logic [XLEN-1:0]    dbg_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [XLEN-1:0]    out,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  logic [31:0]   imem [2**PC_W];
  logic [XLEN-1:0] dmem [2**DADDR_W];

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            ill_q, ill_d;
  logic            busy_q, busy_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic [XLEN-1:0] simm, zimm;
  logic [PC_W-1:0] pc_inc;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign simm   = {{(XLEN-16){imm[15]}}, imm};
  assign zimm   = {{(XLEN-16){1'b0}}, imm};
  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    we_d    = we_q;
    wa_d    = wa_q;
    out_d   = out_q;
    ill_d   = ill_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        pc_d    = pc_inc;
        we_d    = 1'b1;
        wa_d    = rt;
        case (op)
          6'd0: begin
            wa_d = rd;
            case (funct)
              6'd1, 6'd3: res_d = a_q + b_q;
              6'd2, 6'd4: res_d = a_q - b_q;
              6'd5:  res_d = a_q & b_q;
              6'd6:  res_d = a_q | b_q;
              6'd9:  res_d = XLEN'($signed(a_q) < $signed(b_q));
              6'd10: res_d = XLEN'(a_q < b_q);
              6'd11: res_d = a_q << b_q[4:0];
              6'd12: res_d = a_q >> b_q[4:0];
              default: begin
                we_d    = 1'b0;
                ill_d   = 1'b1;
                state_d = S_FETCH;
              end
            endcase
          end
          6'd2, 6'd3: res_d = a_q + simm;
          6'd4:  res_d = a_q & zimm;
          6'd5:  res_d = a_q | zimm;
          6'd6:  res_d = a_q << imm[4:0];
          6'd7:  res_d = a_q >> imm[4:0];
          6'd16: res_d = XLEN'($signed(a_q) < $signed(simm));
          6'd9: begin
            res_d   = a_q + simm;
            state_d = S_MEM;
          end
          6'd8: begin
            res_d   = a_q + simm;
            we_d    = 1'b0;
            state_d = S_MEM;
          end
          6'd10, 6'd11, 6'd12,
          6'd13, 6'd14, 6'd15: begin
            we_d    = 1'b0;
            state_d = S_FETCH;
            case (op)
              6'd10:   if ($signed(a_q) <  $signed(b_q)) pc_d = imm[PC_W-1:0];
              6'd11:   if (a_q != b_q) pc_d = imm[PC_W-1:0];
              6'd12:   if (a_q == b_q) pc_d = imm[PC_W-1:0];
              6'd13:   if ($signed(a_q) >  $signed(b_q)) pc_d = imm[PC_W-1:0];
              6'd14:   if ($signed(a_q) >= $signed(b_q)) pc_d = imm[PC_W-1:0];
              default: if ($signed(a_q) <= $signed(b_q)) pc_d = imm[PC_W-1:0];
            endcase
          end
          6'd1: begin
            we_d    = 1'b0;
            state_d = S_FETCH;
            case (rs)
              5'd1: pc_d = imm[PC_W-1:0];
              5'd2: begin
                pc_d    = imm[PC_W-1:0];
                res_d   = {{(XLEN-PC_W){1'b0}}, pc_inc};
                wa_d    = 5'd31;
                we_d    = 1'b1;
                state_d = S_WB;
              end
              5'd3: pc_d = b_q[PC_W-1:0];
              default: ill_d = 1'b1;
            endcase
          end
          6'd63: begin
            we_d    = 1'b0;
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: begin
            we_d    = 1'b0;
            ill_d   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (op == 6'd9) res_d = dmem[res_q[DADDR_W-1:0]];
        state_d = S_WB;
      end
      S_WB: begin
        if (we_q) begin
          out_d = res_q;
          if (wa_q != 5'd0) regs_d[wa_q] = res_q;
        end
        we_d    = 1'b0;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      out_q   <= '0;
      ill_q   <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
      regs_q  <= regs_d;
    end
  end

  // Memories keep their contents across reset; external loads only while idle.
  always_ff @(posedge clk) begin
    if (imem_we && !busy_q) imem[imem_waddr] <= imem_wdata;
    if (dmem_we && !busy_q) begin
      dmem[dmem_addr] <= dmem_wdata;
    end else if (!rst && state_q == S_MEM && op == 6'd8) begin
      dmem[res_q[DADDR_W-1:0]] <= b_q;
    end
  end

  assign dbg_rdata = dmem[dmem_addr];
  assign pc        = pc_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign halted    = halt_q;
  assign illegal   = ill_q;

endmodule
